// File: rtl/clk_div_multi.sv
// clk_div_multi: CH-channel programmable clock divider.
// Each channel divides iCLK by a runtime divisor and produces a divided clock
// (oCLK), a one-cycle period-start strobe (oTICK) and a divisor-adopted pulse
// (oUPD). New divisors are adopted only at a period boundary, or while idle.
// Optional build macro: CLK_DIV_DUTY50_EN adds a negedge resample so that odd
// divisors get an exact 50% duty cycle. Without it no negedge logic is built.
//
// Per-channel state machine (run_q):
//   idle (run_q=0): cnt held at 0, outputs low; with iEN=1 A reloads from iDIV
//                   every edge, and the channel starts running on the edge
//                   after a load (arm_q) when the divisor is non-zero.
//   run  (run_q=1): cnt counts 0..A-1; A reloads at cnt==A-1; iEN=0 or a
//                   reloaded divisor of 0 returns the channel to idle.
module clk_div_multi #(
    parameter int CH   = 4,
    parameter int WIDE = 32
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [CH-1:0]      iEN,
    input  logic [CH*WIDE-1:0] iDIV,
    output logic [CH-1:0]      oCLK,
    output logic [CH-1:0]      oTICK,
    output logic [CH-1:0]      oUPD
);

    localparam logic [WIDE-1:0] ONE = WIDE'(1);

    logic [WIDE-1:0] a_q   [CH];
    logic [WIDE-1:0] a_d   [CH];
    logic [WIDE-1:0] cnt_q [CH];
    logic [WIDE-1:0] cnt_d [CH];
    logic [WIDE-1:0] thr_d [CH];
    logic [WIDE-1:0] div_w [CH];
    logic [CH-1:0]   run_q, run_d;
    logic [CH-1:0]   arm_q, arm_d;
    logic [CH-1:0]   upd_q, upd_d;
    logic [CH-1:0]   q_pos_q, q_pos_d;
    logic [CH-1:0]   clk_src;

    // Slice the packed divisor bus into one word per channel.
    for (genvar g = 0; g < CH; g++) begin : g_div
        assign div_w[g] = iDIV[g*WIDE +: WIDE];
    end

    // Next-state: divisor adoption, counter, run/idle and the q_pos decode.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            a_d[k]   = a_q[k];
            cnt_d[k] = cnt_q[k];
            run_d[k] = run_q[k];
            arm_d[k] = 1'b0;
            if (run_q[k]) begin
                if (!iEN[k]) begin
                    run_d[k] = 1'b0;
                    cnt_d[k] = '0;
                end else if (cnt_q[k] == a_q[k] - ONE) begin
                    a_d[k]   = div_w[k];
                    cnt_d[k] = '0;
                    run_d[k] = (div_w[k] != '0);
                end else begin
                    cnt_d[k] = cnt_q[k] + ONE;
                end
            end else begin
                cnt_d[k] = '0;
                if (iEN[k]) begin
                    a_d[k]   = div_w[k];
                    arm_d[k] = 1'b1;
                    run_d[k] = arm_q[k] && (div_w[k] != '0);
                end
            end
            upd_d[k] = (a_d[k] != a_q[k]);
            // High phase lasts H cycles for even A, H+1 for odd A (H = A>>1);
            // H + A[0] cannot overflow WIDE bits for any A.
            thr_d[k]   = (a_d[k] >> 1) + {{(WIDE-1){1'b0}}, a_d[k][0]};
            q_pos_d[k] = run_d[k] && (cnt_d[k] < thr_d[k]);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int k = 0; k < CH; k++) begin
                a_q[k]   <= '0;
                cnt_q[k] <= '0;
            end
            run_q   <= '0;
            arm_q   <= '0;
            upd_q   <= '0;
            q_pos_q <= '0;
        end else begin
            for (int k = 0; k < CH; k++) begin
                a_q[k]   <= a_d[k];
                cnt_q[k] <= cnt_d[k];
            end
            run_q   <= run_d;
            arm_q   <= arm_d;
            upd_q   <= upd_d;
            q_pos_q <= q_pos_d;
        end
    end

`ifdef CLK_DIV_DUTY50_EN
    logic [CH-1:0] q_neg_q, q_neg_d;

    // Half-cycle delayed copy of q_pos for odd-divisor duty correction.
    always_comb begin
        q_neg_d = q_pos_q;
    end

    // q_pos resampled on the falling edge of iCLK.
    always_ff @(negedge iCLK) begin
        if (iRST) q_neg_q <= '0;
        else      q_neg_q <= q_neg_d;
    end

    // Odd A: AND with the delayed copy trims the high phase to exactly A/2.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            clk_src[k] = a_q[k][0] ? (q_pos_q[k] & q_neg_q[k]) : q_pos_q[k];
        end
    end
`else
    // Divided clock taken straight from the registered decode.
    always_comb begin
        clk_src = q_pos_q;
    end
`endif

    // Output decode: tick at cnt==0 while running, A==1 passes iCLK through.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            oTICK[k] = run_q[k] && (cnt_q[k] == '0);
            oCLK[k]  = (run_q[k] && a_q[k] == ONE) ? (iCLK & iEN[k]) : clk_src[k];
        end
        oUPD = upd_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed testbench for clk_div_multi (CH=4, WIDE=32).
module tb_clk_div_multi;

    localparam int CH   = 4;
    localparam int WIDE = 32;

    logic               iCLK = 1'b0;
    logic               iRST;
    logic [CH-1:0]      iEN;
    logic [CH*WIDE-1:0] iDIV;
    logic [CH-1:0]      oCLK;
    logic [CH-1:0]      oTICK;
    logic [CH-1:0]      oUPD;

    int n_tests = 0;
    int n_fail  = 0;
    int divs [CH];

    clk_div_multi #(.CH(CH), .WIDE(WIDE)) dut (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iEN   (iEN),
        .iDIV  (iDIV),
        .oCLK  (oCLK),
        .oTICK (oTICK),
        .oUPD  (oUPD)
    );

    // Clock and reset block.
    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic set_div(input int k, input int val);
        iDIV[k*WIDE +: WIDE] = WIDE'(val);
    endtask

    // Expected oCLK level at cnt c for divisor a (sampled just after posedge).
    function automatic logic exp_clk(input int a, input int c);
`ifdef CLK_DIV_DUTY50_EN
        if (a % 2 == 1) return (c >= 1) && (c < a / 2 + 1);
`endif
        return c < (a / 2 + a % 2);
    endfunction

    // Expected tick / clock vectors for all channels at cycle n of a run.
    task automatic check_all(input string tag, input int n);
        logic [CH-1:0] et, ec;
        for (int k = 0; k < CH; k++) begin
            et[k] = ((n % divs[k]) == 0);
            ec[k] = exp_clk(divs[k], n % divs[k]);
        end
        check({tag, "_tick"}, 32'(oTICK), 32'(et));
        check({tag, "_clk"},  32'(oCLK),  32'(ec));
    endtask

    initial begin
        // Reset state.
        iRST = 1'b1;
        iEN  = '0;
        iDIV = '0;
        step();
        step();
        check("rst_clk",  32'(oCLK),  0);
        check("rst_tick", 32'(oTICK), 0);
        check("rst_upd",  32'(oUPD),  0);

        // ch0 divide by 4; edge 1 loads A, edge 2 starts the first period.
        iRST = 1'b0;
        iEN  = 4'b0001;
        set_div(0, 4);
        step();
        check("d4_e1_tick", 32'(oTICK), 0);
        check("d4_e1_clk",  32'(oCLK),  0);
        check("d4_e1_upd",  32'(oUPD),  1);
        for (int i = 0; i < 8; i++) begin
            step();
            check("d4_tick", 32'(oTICK), 32'((i % 4) == 0));
            check("d4_clk",  32'(oCLK),  32'(exp_clk(4, i % 4)));
            check("d4_upd",  32'(oUPD),  0);
        end

        // Divisor 5 adopted at the next boundary (current cnt is 3).
        set_div(0, 5);
        for (int j = 0; j < 10; j++) begin
            step();
            check("d5_tick", 32'(oTICK), 32'((j % 5) == 0));
            check("d5_clk",  32'(oCLK),  32'(exp_clk(5, j % 5)));
            check("d5_upd",  32'(oUPD),  32'(j == 0));
        end

        // A=6, request 3 at cnt=2; the 6-cycle period must complete first.
        set_div(0, 6);
        for (int p = 0; p < 6; p++) begin
            step();
            check("d6_tick", 32'(oTICK), 32'(p == 0));
            check("d6_clk",  32'(oCLK),  32'(exp_clk(6, p)));
            check("d6_upd",  32'(oUPD),  32'(p == 0));
            if (p == 2) set_div(0, 3);
        end
        for (int r = 0; r < 6; r++) begin
            step();
            check("d3_tick", 32'(oTICK), 32'((r % 3) == 0));
            check("d3_clk",  32'(oCLK),  32'(exp_clk(3, r % 3)));
            check("d3_upd",  32'(oUPD),  32'(r == 0));
        end

        // ch1 divide by 1: bypass of iCLK, tick every cycle.
        iEN = 4'b0011;
        set_div(1, 1);
        step();
        check("d1_e1_upd",  32'(oUPD[1]),  1);
        check("d1_e1_tick", 32'(oTICK[1]), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("d1_tick",    32'(oTICK[1]), 1);
            check("d1_clk_hi",  32'(oCLK[1]),  1);
            check("d1_upd",     32'(oUPD[1]),  0);
            @(negedge iCLK);
            #1;
            check("d1_clk_lo",  32'(oCLK[1]),  0);
        end
        iEN = 4'b0001;
        step();
        check("d1_off_tick", 32'(oTICK[1]), 0);
        check("d1_off_clk",  32'(oCLK[1]),  0);

        // All channels 2,3,7,10 from a clean reset, then a mid-period reset.
        iRST = 1'b1;
        divs[0] = 2; divs[1] = 3; divs[2] = 7; divs[3] = 10;
        for (int k = 0; k < CH; k++) set_div(k, divs[k]);
        iEN = 4'b1111;
        step();
        iRST = 1'b0;
        step();
        check("all_e1_upd",  32'(oUPD),  32'hf);
        check("all_e1_tick", 32'(oTICK), 0);
        for (int n = 0; n < 5; n++) begin
            step();
            check_all("all_a", n);
        end
        iRST = 1'b1;
        step();
        check("mid_rst_clk",  32'(oCLK),  0);
        check("mid_rst_tick", 32'(oTICK), 0);
        check("mid_rst_upd",  32'(oUPD),  0);
        iRST = 1'b0;
        step();
        check("rel_e1_tick", 32'(oTICK), 0);
        check("rel_e1_clk",  32'(oCLK),  0);
        check("rel_e1_upd",  32'(oUPD),  32'hf);
        for (int n = 0; n < 12; n++) begin
            step();
            check_all("all_b", n);
            check("all_b_upd", 32'(oUPD), 0);
        end

        // ch2 divide by 8, drop enable at cnt=3, then re-enable.
        iRST = 1'b1;
        iDIV = '0;
        set_div(2, 8);
        iEN = 4'b0100;
        step();
        iRST = 1'b0;
        step();
        for (int c = 0; c < 4; c++) begin
            step();
            check("d8_tick", 32'(oTICK), 32'(((c == 0) ? 1 : 0) << 2));
            check("d8_clk",  32'(oCLK),  32'(32'(exp_clk(8, c)) << 2));
        end
        iEN = 4'b0000;
        step();
        check("en_off_tick", 32'(oTICK), 0);
        check("en_off_clk",  32'(oCLK),  0);
        step();
        check("en_idle_tick", 32'(oTICK), 0);
        check("en_idle_clk",  32'(oCLK),  0);
        iEN = 4'b0100;
        step();
        check("en_on_e1_tick", 32'(oTICK), 0);
        check("en_on_e1_upd",  32'(oUPD),  0);
        for (int c = 0; c < 9; c++) begin
            step();
            check("re8_tick", 32'(oTICK), 32'((((c % 8) == 0) ? 1 : 0) << 2));
            check("re8_clk",  32'(oCLK),  32'(32'(exp_clk(8, c % 8)) << 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider, the successor to the single-channel odd/even divider in the chunk library.
- Each of CH channels divides iCLK by a runtime divisor.
- Each channel produces a divided clock (oCLK) and a one-iCLK-cycle enable strobe (oTICK).
- Divisor changes are glitch-free: a new divisor is adopted only at a period boundary.
- Used to derive pixel, scan and sample rates for the video and recognition datapaths from the single board clock.

Parameters:
- CH, 4: number of independent channels.
- WIDE, 32: divisor width per channel.

Ports:
- iCLK  input  1  system clock; all state updates on posedge.
- iRST  input  1  synchronous, active-high reset.
- iEN  input  CH  per-channel run enable.
- iDIV  input  CH*WIDE  per-channel divisor; channel k occupies bits [k*WIDE +: WIDE].
- oCLK  output  CH  divided clock per channel.
- oTICK  output  CH  one-cycle strobe at the start of each divided period.
- oUPD  output  CH  one-cycle pulse when a channel adopts a new divisor.

Behaviour:
- Reset (iRST=1 at posedge): for every channel, active divisor A=0, counter cnt=0, q_pos=0, q_neg=0. oCLK, oTICK and oUPD are all 0.
- Idle state: a channel is idle when A==0 or iEN[k]==0.
  - While idle: cnt is held at 0; oCLK=0; oTICK=0.
  - While idle and iEN[k]=1: A loads iDIV[k] at every posedge.
  - oUPD[k] pulses for one cycle whenever the loaded value differs from the previous A.
- Run state (A>=2):
  - cnt counts 0..A-1 and wraps to 0.
  - At the posedge where cnt==A-1, A loads iDIV[k] (period-boundary update).
  - oUPD[k] pulses in the following cycle if the value changed.
  - If the new value is 0, the channel enters idle: cnt=0, outputs low.
- oTICK[k]: high for the whole cycle in which cnt==0 and the channel is running. Exactly one tick per A cycles.
- q_pos (define H = A>>1):
  - q_pos is registered and updated with the next-cnt decode, so it is cycle-aligned with cnt.
  - Even A: q_pos=1 for cnt in [0,H-1].
  - Odd A: q_pos=1 for cnt in [0,H].
- q_neg: q_pos resampled on negedge iCLK; used only for odd A (see DUTY50_EN).
- A==1: oCLK[k] = iCLK (combinational bypass, gated by iEN[k]); oTICK[k]=1 every cycle.
- Latency from reset release with iEN=1 and iDIV=D:
  - Edge 1: A=D.
  - Edge 2: channel running, cnt=0; oTICK and oCLK rise together.
- iEN falling mid-period: at the next posedge the channel goes idle immediately with cnt=0. A is retained.
- iEN rising: counting restarts at cnt=0, giving a fresh, phase-aligned period.
- Reset mid-operation: all channels are forced to the reset state at that edge, regardless of iEN or iDIV.
- Channels are fully independent. Simultaneous boundary updates on several channels are all honoured in the same cycle.
- Arithmetic: cnt, A and H are WIDE bits; no overflow for any A up to 2^WIDE-1.

Optional Feature:
- Macro: CLK_DIV_DUTY50_EN.
- Defined:
  - Odd A: oCLK = q_pos & q_neg. High time is exactly A/2 iCLK periods (50% duty).
  - Even A: oCLK = q_pos.
- Undefined:
  - No negedge logic is built; oCLK = q_pos for all A.
  - Odd A: high for H+1 of A cycles. Example: A=5 gives 3 high, 2 low.
- In both builds: oTICK and oUPD behaviour, and the A==1 bypass, are unchanged.

Test Plan:
- Reset, then iEN=4'b0001, ch0 iDIV=4 -> ch0 A=4 after edge 1; oTICK every 4 cycles starting edge 2; oCLK 2 high/2 low; ch1-3 outputs stay 0.
- ch0 iDIV=5 with DUTY50_EN defined -> oCLK high 2.5 periods, low 2.5 periods; oTICK every 5 cycles. Without the macro -> 3 high/2 low.
- ch0 running A=6, change iDIV to 3 at cnt=2 -> period completes at 6; oUPD pulse one cycle after the cnt==5 edge; next period is 3 cycles; no runt pulse on oCLK.
- ch1 iDIV=1, iEN[1]=1 -> oCLK[1] follows iCLK; oTICK[1] constantly 1. Set iEN[1]=0 -> both 0.
- All channels running with divisors 2, 3, 7, 10; assert iRST for 1 cycle mid-period -> all outputs 0 on the next cycle; periods resume phase-aligned from cnt=0 two edges after release.
- ch2 running A=8; drop iEN[2] at cnt=3 -> outputs 0 at the next edge. Re-raise -> oTICK on the second edge after rising; full 8-cycle period follows.
